// File: rtl/line_decoder.sv
// 3-to-8 reversed-index one-hot decoder with a clocked status side-channel
// (registered copy of F, sticky seen mask, saturating enabled-cycle count).
module line_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Enable,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic [7:0]       F,
  output logic [7:0]       F_q,
  output logic [7:0]       seen,
  output logic [CNT_W-1:0] en_count
);

  localparam int unsigned LINES = 8;
  localparam int unsigned SEL_W = 3;

  logic [SEL_W-1:0] w_sel;
  logic [LINES-1:0] w_f;
  logic [SEL_W-1:0] w_idx;

  logic [LINES-1:0] r_f_q;
  logic [LINES-1:0] r_seen;
  logic [CNT_W-1:0] r_cnt;

  assign w_sel = {A, B, C};
  assign w_idx = SEL_W'(3'd7 - w_sel);

  // Pure combinational decode; a known Enable=0 forces an X-free zero.
  always_comb begin
    w_f = '0;
    if (Enable) begin
      w_f[w_idx] = 1'b1;
    end
  end

  assign F = w_f;

  // Side-channel status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_q  <= '0;
      r_seen <= '0;
      r_cnt  <= '0;
    end else begin
      r_f_q  <= w_f;
      r_seen <= r_seen | w_f;
      if (Enable && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign F_q      = r_f_q;
  assign seen     = r_seen;
  assign en_count = r_cnt;

endmodule

// File: tb/tb_line_decoder.sv
// Directed self-checking bench for line_decoder; a second instance with
// CNT_W=2 exercises counter saturation.
module tb_line_decoder;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       en, a, b, c;

  logic [7:0] f8, fq8, seen8;
  logic [7:0] cnt8;
  logic [7:0] f2, fq2, seen2;
  logic [1:0] cnt2;

  int vectors;
  int miscompares;

  line_decoder #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .Enable(en), .A(a), .B(b), .C(c),
    .F(f8), .F_q(fq8), .seen(seen8), .en_count(cnt8)
  );

  line_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .Enable(en), .A(a), .B(b), .C(c),
    .F(f2), .F_q(fq2), .seen(seen2), .en_count(cnt2)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    vectors++;
    if (fq8 !== 8'h00 || seen8 !== 8'h00 || cnt8 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset8: F_q=%b seen=%b en_count=%0d, want 0/0/0", fq8, seen8, cnt8);
    end
    vectors++;
    if (fq2 !== 8'h00 || seen2 !== 8'h00 || cnt2 !== 2'd0) begin
      miscompares++;
      $display("FAIL reset2: F_q=%b seen=%b en_count=%0d, want 0/0/0", fq2, seen2, cnt2);
    end
  endtask

  task automatic test_comb_no_clock();
    {en, a, b, c} = 4'b1110;
    #5;
    vectors++;
    if (f8 !== 8'b00000010) begin
      miscompares++;
      $display("FAIL comb_no_clock: F=%b, want 00000010", f8);
    end
  endtask

  task automatic test_decode_enabled();
    logic [7:0] exp;
    en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      {a, b, c} = 3'(n);
      exp = 8'b10000000 >> n;
      #1;
      vectors++;
      if (f8 !== exp || f2 !== exp) begin
        miscompares++;
        $display("FAIL decode_en code=%0d: F=%b/%b, want %b", n, f8, f2, exp);
      end
    end
  endtask

  task automatic test_decode_disabled();
    en = 1'b0;
    for (int n = 0; n < 8; n++) begin
      {a, b, c} = 3'(n);
      #1;
      vectors++;
      if (f8 !== 8'h00) begin
        miscompares++;
        $display("FAIL decode_dis code=%0d: F=%b, want 00000000", n, f8);
      end
    end
  endtask

  task automatic test_seen_and_async_reset();
    clk_en = 1'b1;
    rst_n  = 1'b0;
    #2;
    rst_n = 1'b1;
    en = 1'b1;
    {a, b, c} = 3'b000;
    tick();
    {a, b, c} = 3'b111;
    tick();
    vectors++;
    if (fq8 !== 8'b00000001 || seen8 !== 8'b10000001) begin
      miscompares++;
      $display("FAIL seen: F_q=%b seen=%b, want 00000001/10000001", fq8, seen8);
    end
    vectors++;
    if (cnt8 !== 8'd2 || cnt2 !== 2'd2) begin
      miscompares++;
      $display("FAIL seen_count: en_count=%0d/%0d, want 2/2", cnt8, cnt2);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (fq8 !== 8'h00 || seen8 !== 8'h00 || cnt8 !== 8'h00 || cnt2 !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset: F_q=%b seen=%b en_count=%0d/%0d, want all 0",
               fq8, seen8, cnt8, cnt2);
    end
    vectors++;
    if (f8 !== 8'b00000001) begin
      miscompares++;
      $display("FAIL f_in_reset: F=%b, want 00000001", f8);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp2 [5];
    exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
    en = 1'b1;
    {a, b, c} = 3'b101;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (cnt2 !== exp2[k] || cnt8 !== 8'(k + 1)) begin
        miscompares++;
        $display("FAIL saturate edge=%0d: en_count=%0d/%0d, want %0d/%0d",
                 k + 1, cnt2, cnt8, exp2[k], k + 1);
      end
    end
  endtask

  task automatic test_enable_between_edges();
    en = 1'b0;
    #2;
    en = 1'b1;
    #2;
    en = 1'b0;
    tick();
    vectors++;
    if (cnt8 !== 8'd5 || fq8 !== 8'h00) begin
      miscompares++;
      $display("FAIL en_glitch: en_count=%0d F_q=%b, want 5/00000000", cnt8, fq8);
    end
  endtask

  task automatic test_disabled_after_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      {a, b, c} = 3'(k * 3);
      tick();
      vectors++;
      if (fq8 !== 8'h00 || seen8 !== 8'h00 || cnt8 !== 8'h00 || cnt2 !== 2'd0) begin
        miscompares++;
        $display("FAIL disabled edge=%0d: F_q=%b seen=%b en_count=%0d/%0d, want all 0",
                 k + 1, fq8, seen8, cnt8, cnt2);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk_en      = 1'b0;
    en = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    test_reset();
    test_comb_no_clock();
    test_decode_enabled();
    test_decode_disabled();
    test_seen_and_async_reset();
    test_saturation();
    test_enable_between_edges();
    test_disabled_after_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_decoder.md
Name: line_decoder

Overview:
- 3-to-8 line decoder with active-high enable; A is the MSB of the select code, C the LSB.
- Output F is purely combinational, reversed-index one-hot: select code n asserts F[7-n].
- A clocked side-channel adds a registered copy of F, a sticky per-line "seen" mask and a saturating count of enabled cycles, for status/debug logic in the enclosing design.

Parameters:
- CNT_W, 8, width of the enabled-cycle counter.

Ports:
- clk  input  1  rising-edge clock for registered outputs only.
- rst_n  input  1  asynchronous active-low reset, clears registered outputs.
- Enable  input  1  decoder enable, active high.
- A  input  1  select bit 2 (MSB).
- B  input  1  select bit 1.
- C  input  1  select bit 0 (LSB).
- F  output  8  combinational decoded output.
- F_q  output  8  F registered on clk.
- seen  output  8  sticky OR of every F value sampled while rst_n high.
- en_count  output  CNT_W  saturating count of clk edges with Enable=1.

Behaviour:
- Select code n = {A,B,C}, 0..7.
- Enable=1: F[7-n]=1, all other F bits 0. Exactly one bit set.
- Enable=0: F=8'b00000000 regardless of A/B/C.
- F has zero latency and no dependence on clk or rst_n. It stays correct while in reset and with no clock running.
- Any X/Z on Enable, A, B or C yields an X-free result only when Enable=0 is known; otherwise F is don't-care.
- Full mapping (ABC -> F, Enable=1):
  - 000->10000000, 001->01000000, 010->00100000, 011->00010000
  - 100->00001000, 101->00000100, 110->00000010, 111->00000001
- Registered path, on rst_n falling edge (asynchronous, immediate): F_q=0, seen=0, en_count=0.
- Registered path, on each clk rising edge with rst_n=1:
  - F_q <= F.
  - seen <= seen | F.
  - en_count <= en_count+1 if Enable=1 and en_count != all-ones; otherwise it holds.
- en_count saturates at 2^CNT_W-1 and never wraps.
- Reset released between edges: the first clk edge after release updates normally.
- Reset asserted mid-run: registered outputs clear immediately; F keeps following its inputs.
- Enable toggling between edges: only the value at the clk edge matters for F_q, seen and en_count.

Test Plan:
- {Enable,A,B,C}=4'b1110, no clock, wait 5 time units -> F=8'b00000010.
- Enable=1, sweep ABC 000..111 -> F = 10000000, 01000000, ... 00000001 in that order, exactly one bit high each time.
- Enable=0, sweep all eight ABC codes -> F=00000000 each time.
- rst_n=0 then 1; Enable=1, ABC=000 for one clk edge, then ABC=111 for one edge:
  - after the edges, F_q=00000001 and seen=10000001.
  - then rst_n=0 without a clock edge -> F_q, seen and en_count all 0 immediately.
- CNT_W=2, Enable=1 for 5 clk edges -> en_count reads 1,2,3,3,3.
- Enable=0 for 3 clk edges after reset -> F_q=0, seen=0, en_count=0.
